// File: rtl/portctl_kbfifo.sv
// portctl_kbfifo: CPU I/O port decoder for the PS/2 keyboard (60h/64h) and the
// CGA CRTC register pair (3D4h/3D5h). Received set-2 scancodes are translated
// to XT set 1 and buffered in a FIFO; the CRTC block exposes cursor shape,
// cursor address and display start address.
module portctl_kbfifo #(
    parameter int unsigned FIFO_AW  = 4,
    parameter int unsigned CURSOR_W = 11
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                port_clk,
    input  logic [15:0]         port,
    input  logic                port_w,
    input  logic [7:0]          port_o,
    output logic [7:0]          port_i,
    input  logic [7:0]          ps2_data,
    input  logic                ps2_hit,
    output logic                irq1,
    output logic [CURSOR_W-1:0] vga_cursor,
    output logic [CURSOR_W-1:0] vga_start,
    output logic [9:0]          cursor_shape
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    localparam logic [15:0] P_KBD_DATA = 16'h0060;
    localparam logic [15:0] P_KBD_STAT = 16'h0064;
    localparam logic [15:0] P_CRTC_IDX = 16'h03D4;
    localparam logic [15:0] P_CRTC_DAT = 16'h03D5;

    typedef logic [FIFO_AW:0]   cnt_t;
    typedef logic [FIFO_AW-1:0] ptr_t;

    // AT set 2 make code to XT set 1 make code; unlisted codes pass through.
    function automatic logic [7:0] xlat(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        case (c)
            8'h76: r = 8'h01; // ESC
            8'h05: r = 8'h3B; // F1
            8'h06: r = 8'h3C; // F2
            8'h04: r = 8'h3D; // F3
            8'h0C: r = 8'h3E; // F4
            8'h03: r = 8'h3F; // F5
            8'h0B: r = 8'h40; // F6
            8'h83: r = 8'h41; // F7
            8'h0A: r = 8'h42; // F8
            8'h01: r = 8'h43; // F9
            8'h09: r = 8'h44; // F10
            8'h78: r = 8'h57; // F11
            8'h07: r = 8'h58; // F12
            8'h0E: r = 8'h29; // `
            8'h16: r = 8'h02; // 1
            8'h1E: r = 8'h03; // 2
            8'h26: r = 8'h04; // 3
            8'h25: r = 8'h05; // 4
            8'h2E: r = 8'h06; // 5
            8'h36: r = 8'h07; // 6
            8'h3D: r = 8'h08; // 7
            8'h3E: r = 8'h09; // 8
            8'h46: r = 8'h0A; // 9
            8'h45: r = 8'h0B; // 0
            8'h4E: r = 8'h0C; // -
            8'h55: r = 8'h0D; // =
            8'h66: r = 8'h0E; // BS
            8'h0D: r = 8'h0F; // TAB
            8'h15: r = 8'h10; // Q
            8'h1D: r = 8'h11; // W
            8'h24: r = 8'h12; // E
            8'h2D: r = 8'h13; // R
            8'h2C: r = 8'h14; // T
            8'h35: r = 8'h15; // Y
            8'h3C: r = 8'h16; // U
            8'h43: r = 8'h17; // I
            8'h44: r = 8'h18; // O
            8'h4D: r = 8'h19; // P
            8'h54: r = 8'h1A; // [
            8'h5B: r = 8'h1B; // ]
            8'h5A: r = 8'h1C; // ENTER
            8'h14: r = 8'h1D; // LCTRL
            8'h1C: r = 8'h1E; // A
            8'h1B: r = 8'h1F; // S
            8'h23: r = 8'h20; // D
            8'h2B: r = 8'h21; // F
            8'h34: r = 8'h22; // G
            8'h33: r = 8'h23; // H
            8'h3B: r = 8'h24; // J
            8'h42: r = 8'h25; // K
            8'h4B: r = 8'h26; // L
            8'h4C: r = 8'h27; // ;
            8'h52: r = 8'h28; // '
            8'h12: r = 8'h2A; // LSHIFT
            8'h5D: r = 8'h2B; // backslash
            8'h1A: r = 8'h2C; // Z
            8'h22: r = 8'h2D; // X
            8'h21: r = 8'h2E; // C
            8'h2A: r = 8'h2F; // V
            8'h32: r = 8'h30; // B
            8'h31: r = 8'h31; // N
            8'h3A: r = 8'h32; // M
            8'h41: r = 8'h33; // ,
            8'h49: r = 8'h34; // .
            8'h4A: r = 8'h35; // /
            8'h59: r = 8'h36; // RSHIFT
            8'h7C: r = 8'h37; // KP *
            8'h11: r = 8'h38; // LALT
            8'h29: r = 8'h39; // SPACE
            8'h58: r = 8'h3A; // CAPS
            8'h77: r = 8'h45; // NUMLOCK
            8'h7E: r = 8'h46; // SCROLLLOCK
            8'h6C: r = 8'h47; // KP 7
            8'h75: r = 8'h48; // KP 8
            8'h7D: r = 8'h49; // KP 9
            8'h7B: r = 8'h4A; // KP -
            8'h6B: r = 8'h4B; // KP 4
            8'h73: r = 8'h4C; // KP 5
            8'h74: r = 8'h4D; // KP 6
            8'h79: r = 8'h4E; // KP +
            8'h69: r = 8'h4F; // KP 1
            8'h72: r = 8'h50; // KP 2
            8'h7A: r = 8'h51; // KP 3
            8'h70: r = 8'h52; // KP 0
            8'h71: r = 8'h53; // KP .
            default: r = c;
        endcase
        return r;
    endfunction

    logic [7:0]          r_mem [DEPTH];
    ptr_t                r_wr_ptr;
    ptr_t                r_rd_ptr;
    cnt_t                r_count;
    logic                r_ovf;
    logic                r_rel;
    logic                r_kbd_en;
    logic [7:0]          r_hold;
    logic [7:0]          r_port_i;
    logic [4:0]          r_idx;
    logic [4:0]          r_shape_start;
    logic [4:0]          r_shape_end;
    logic [CURSOR_W-1:0] r_cursor;
    logic [CURSOR_W-1:0] r_start;

    logic       w_rd;
    logic       w_wr;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_head;
    logic       w_is_f0;
    logic       w_is_prefix;
    logic [7:0] w_xlat;
    logic [7:0] w_enq_byte;
    logic       w_flush;
    logic       w_push_try;
    logic       w_pop;
    logic       w_push;
    logic       w_ovf_set;
    logic [7:0] w_crtc_rd;
    logic [7:0] w_rd_data;

    assign w_rd        = port_clk & ~port_w;
    assign w_wr        = port_clk & port_w;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == cnt_t'(DEPTH));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_is_f0     = (ps2_data == 8'hF0);
    assign w_is_prefix = (ps2_data == 8'hE0) || (ps2_data == 8'hE1);
    assign w_xlat      = xlat(ps2_data);
    assign w_enq_byte  = w_is_prefix ? ps2_data : {r_rel | w_xlat[7], w_xlat[6:0]};

    // A flush drops any byte arriving on the same edge. When full, a push only
    // lands if a pop frees the slot on that same edge; otherwise it overflows.
    assign w_flush    = w_wr && (port == P_KBD_STAT) && (port_o == 8'hAE);
    assign w_push_try = ps2_hit & ~w_is_f0 & r_kbd_en & ~w_flush;
    assign w_pop      = w_rd && (port == P_KBD_DATA) && !w_empty;
    assign w_push     = w_push_try & (~w_full | w_pop);
    assign w_ovf_set  = w_push_try & w_full & ~w_pop;

    // CRTC data register readback, selected by the current index.
    always_comb begin
        w_crtc_rd = '0;
        case (r_idx)
            5'h0A:   w_crtc_rd = {3'b000, r_shape_start};
            5'h0B:   w_crtc_rd = {3'b000, r_shape_end};
            5'h0C:   w_crtc_rd = 8'(r_start >> 8);
            5'h0D:   w_crtc_rd = r_start[7:0];
            5'h0E:   w_crtc_rd = 8'(r_cursor >> 8);
            5'h0F:   w_crtc_rd = r_cursor[7:0];
            default: w_crtc_rd = '0;
        endcase
    end

    // Port read data mux; unmapped addresses float high.
    always_comb begin
        w_rd_data = '1;
        case (port)
            P_KBD_DATA: w_rd_data = w_empty ? r_hold : w_head;
            P_KBD_STAT: w_rd_data = {r_ovf, 5'b00000, ~r_kbd_en, ~w_empty};
            P_CRTC_IDX: w_rd_data = {3'b000, r_idx};
            P_CRTC_DAT: w_rd_data = w_crtc_rd;
            default:    w_rd_data = '1;
        endcase
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_enq_byte;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Keyboard state: release prefix, sticky overflow (set beats clear), enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rel    <= 1'b0;
            r_ovf    <= 1'b0;
            r_kbd_en <= 1'b1;
        end else begin
            if (ps2_hit) begin
                if (w_is_f0)           r_rel <= 1'b1;
                else if (!w_is_prefix) r_rel <= 1'b0;
            end
            if (w_ovf_set)                          r_ovf <= 1'b1;
            else if (w_rd && (port == P_KBD_STAT)) r_ovf <= 1'b0;
            if (w_wr && (port == P_KBD_STAT)) begin
                if (port_o == 8'hAD)      r_kbd_en <= 1'b0;
                else if (port_o == 8'hAE) r_kbd_en <= 1'b1;
            end
        end
    end

    // Read data register and last-popped hold byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_port_i <= '0;
            r_hold   <= '0;
        end else begin
            if (w_rd)  r_port_i <= w_rd_data;
            if (w_pop) r_hold   <= w_head;
        end
    end

    // CRTC index and data registers; high bytes carry bits [CURSOR_W-1:8].
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= '0;
            r_shape_start <= 5'd6;
            r_shape_end   <= 5'd7;
            r_start       <= '0;
            r_cursor      <= '0;
        end else if (w_wr) begin
            if (port == P_CRTC_IDX) begin
                r_idx <= port_o[4:0];
            end else if (port == P_CRTC_DAT) begin
                case (r_idx)
                    5'h0A: r_shape_start <= port_o[4:0];
                    5'h0B: r_shape_end   <= port_o[4:0];
                    5'h0C: r_start  <= (r_start & CURSOR_W'(8'hFF)) | (CURSOR_W'(port_o) << 8);
                    5'h0D: r_start  <= (r_start & ~CURSOR_W'(8'hFF)) | CURSOR_W'(port_o);
                    5'h0E: r_cursor <= (r_cursor & CURSOR_W'(8'hFF)) | (CURSOR_W'(port_o) << 8);
                    5'h0F: r_cursor <= (r_cursor & ~CURSOR_W'(8'hFF)) | CURSOR_W'(port_o);
                    default: ;
                endcase
            end
        end
    end

    assign port_i       = r_port_i;
    assign irq1         = ~w_empty & r_kbd_en;
    assign vga_cursor   = r_cursor;
    assign vga_start    = r_start;
    assign cursor_shape = {r_shape_start, r_shape_end};

endmodule

// File: tb/tb_portctl_kbfifo.sv
// Bench for portctl_kbfifo: table of port/PS2 operations with expected results,
// read data checked through a scoreboard queue, plus hand-written FIFO corner
// sequences and an asynchronous reset check.
module tb_portctl_kbfifo;

    logic        clock;
    logic        reset_n;
    logic        port_clk;
    logic [15:0] port;
    logic        port_w;
    logic [7:0]  port_o;
    logic [7:0]  port_i;
    logic [7:0]  ps2_data;
    logic        ps2_hit;
    logic        irq1;
    logic [10:0] vga_cursor;
    logic [10:0] vga_start;
    logic [9:0]  cursor_shape;

    portctl_kbfifo #(.FIFO_AW(4), .CURSOR_W(11)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .port_clk     (port_clk),
        .port         (port),
        .port_w       (port_w),
        .port_o       (port_o),
        .port_i       (port_i),
        .ps2_data     (ps2_data),
        .ps2_hit      (ps2_hit),
        .irq1         (irq1),
        .vga_cursor   (vga_cursor),
        .vga_start    (vga_start),
        .cursor_shape (cursor_shape)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum {OP_PS2, OP_WR, OP_RD, OP_IRQ, OP_CUR, OP_START, OP_SHAPE, OP_PI} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void add(input op_e op, input logic [15:0] a, input logic [7:0] d,
                                input logic [15:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of stimulus from a falling edge; returns on the next falling edge.
    task automatic step(input logic hit, input logic [7:0] d, input logic pc, input logic pw,
                        input logic [15:0] a, input logic [7:0] wd);
        ps2_hit = hit; ps2_data = d; port_clk = pc; port_w = pw; port = a; port_o = wd;
        @(negedge clock);
        ps2_hit = 1'b0; port_clk = 1'b0; port_w = 1'b0;
    endtask

    task automatic ps2(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b0, 8'h00, 1'b1, 1'b1, a, d);
    endtask

    // Read strobe, optionally with a simultaneous PS/2 byte; result via scoreboard.
    task automatic rd_hit(input logic [15:0] a, input logic hit, input logic [7:0] b,
                          input logic [7:0] e, input string nm);
        logic [7:0] exp_b;
        sb_q.push_back(e);
        step(hit, b, 1'b1, 1'b0, a, 8'h00);
        if (sb_q.size() == 0) begin
            check({nm, "_sb_empty"}, 16'(port_i), 16'hxxxx);
        end else begin
            exp_b = sb_q.pop_front();
            check(nm, 16'(port_i), 16'(exp_b));
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
        rd_hit(a, 1'b0, 8'h00, e, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; port_clk = 1'b0; port = '0; port_w = 1'b0; port_o = '0;
        ps2_data = '0; ps2_hit = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        check("rst_port_i", 16'(port_i), 16'h0000);
        check("rst_irq1", 16'(irq1), 16'h0000);
        check("rst_cursor", 16'(vga_cursor), 16'h0000);
        check("rst_start", 16'(vga_start), 16'h0000);
        check("rst_shape", 16'(cursor_shape), 16'h00C7);

        // Translation, release prefix, hold register
        add(OP_PS2, 0, 8'h1C, 0);       add(OP_IRQ, 0, 0, 16'h1);
        add(OP_RD, 16'h60, 0, 16'h1E);  add(OP_IRQ, 0, 0, 16'h0);
        add(OP_PS2, 0, 8'hF0, 0);       add(OP_PS2, 0, 8'h1C, 0);
        add(OP_RD, 16'h60, 0, 16'h9E);  add(OP_RD, 16'h60, 0, 16'h9E);
        add(OP_IRQ, 0, 0, 16'h0);
        // Extended release
        add(OP_PS2, 0, 8'hE0, 0);       add(OP_PS2, 0, 8'hF0, 0);
        add(OP_PS2, 0, 8'h75, 0);
        add(OP_RD, 16'h60, 0, 16'hE0);  add(OP_RD, 16'h60, 0, 16'hC8);
        add(OP_RD, 16'h64, 0, 16'h00);
        // Unlisted code passes through
        add(OP_PS2, 0, 8'h2F, 0);       add(OP_RD, 16'h60, 0, 16'h2F);
        // CRTC cursor
        add(OP_WR, 16'h3D4, 8'h0E, 0);  add(OP_WR, 16'h3D5, 8'h07, 0);
        add(OP_WR, 16'h3D4, 8'h0F, 0);  add(OP_WR, 16'h3D5, 8'hD0, 0);
        add(OP_CUR, 0, 0, 16'h07D0);
        add(OP_WR, 16'h3D4, 8'h0E, 0);  add(OP_RD, 16'h3D5, 0, 16'h07);
        add(OP_RD, 16'h3D4, 0, 16'h0E);
        add(OP_WR, 16'h3D5, 8'hFF, 0);  add(OP_RD, 16'h3D5, 0, 16'h07);
        add(OP_CUR, 0, 0, 16'h07D0);
        // CRTC display start
        add(OP_WR, 16'h3D4, 8'h0C, 0);  add(OP_WR, 16'h3D5, 8'h05, 0);
        add(OP_WR, 16'h3D4, 8'h0D, 0);  add(OP_WR, 16'h3D5, 8'h34, 0);
        add(OP_START, 0, 0, 16'h0534);  add(OP_RD, 16'h3D5, 0, 16'h34);
        // Cursor shape
        add(OP_WR, 16'h3D4, 8'h0A, 0);  add(OP_WR, 16'h3D5, 8'h20, 0);
        add(OP_SHAPE, 0, 0, 16'h0007);  add(OP_RD, 16'h3D5, 0, 16'h00);
        add(OP_WR, 16'h3D4, 8'h0B, 0);  add(OP_RD, 16'h3D5, 0, 16'h07);
        // Unused index, unmapped port
        add(OP_WR, 16'h3D4, 8'h05, 0);  add(OP_WR, 16'h3D5, 8'h55, 0);
        add(OP_RD, 16'h3D5, 0, 16'h00); add(OP_CUR, 0, 0, 16'h07D0);
        add(OP_RD, 16'h1234, 0, 16'hFF);
        add(OP_WR, 16'h1234, 8'h12, 0); add(OP_PI, 0, 0, 16'hFF);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_PS2:   ps2(vecs[i].data);
                OP_WR:    wr(vecs[i].addr, vecs[i].data);
                OP_RD:    rd(vecs[i].addr, vecs[i].exp[7:0], $sformatf("vec%0d_rd_%h", i, vecs[i].addr));
                OP_IRQ:   check($sformatf("vec%0d_irq1", i), 16'(irq1), vecs[i].exp);
                OP_CUR:   check($sformatf("vec%0d_cursor", i), 16'(vga_cursor), vecs[i].exp);
                OP_START: check($sformatf("vec%0d_start", i), 16'(vga_start), vecs[i].exp);
                OP_SHAPE: check($sformatf("vec%0d_shape", i), 16'(cursor_shape), vecs[i].exp);
                OP_PI:    check($sformatf("vec%0d_port_i", i), 16'(port_i), vecs[i].exp);
                default:  ;
            endcase
        end

        // Overflow: 17 pushes into a 16-deep FIFO
        repeat (17) ps2(8'h16);
        rd(16'h64, 8'h81, "ovf_status");
        rd(16'h64, 8'h01, "ovf_cleared");
        for (int i = 0; i < 16; i++) rd(16'h60, 8'h02, $sformatf("ovf_drain%0d", i));
        rd(16'h64, 8'h00, "ovf_drained");
        check("ovf_irq_low", 16'(irq1), 16'h0);

        // Full with simultaneous push and pop: both succeed, no overflow
        repeat (16) ps2(8'h16);
        check("full_irq", 16'(irq1), 16'h1);
        rd_hit(16'h60, 1'b1, 8'h1E, 8'h02, "full_pushpop");
        rd(16'h64, 8'h01, "full_pushpop_status");
        for (int i = 0; i < 15; i++) rd(16'h60, 8'h02, $sformatf("full_drain%0d", i));
        rd(16'h60, 8'h03, "full_last_entry");
        rd(16'h64, 8'h00, "full_drained");

        // Status read on the edge that overflows: old value read, ovf stays set
        repeat (16) ps2(8'h1C);
        rd_hit(16'h64, 1'b1, 8'h1C, 8'h01, "setwins_read");
        rd(16'h64, 8'h81, "setwins_sticky");
        rd(16'h64, 8'h01, "setwins_cleared");
        wr(16'h64, 8'hAE);
        rd(16'h64, 8'h00, "flush_full");
        check("flush_irq", 16'(irq1), 16'h0);

        // Disable drops bytes but still tracks release prefix
        wr(16'h64, 8'hAD);
        ps2(8'h1C);
        rd(16'h64, 8'h02, "disabled_status");
        check("disabled_irq", 16'(irq1), 16'h0);
        ps2(8'hF0);
        wr(16'h64, 8'h55);
        rd(16'h64, 8'h02, "other_cmd_ignored");
        wr(16'h64, 8'hAE);
        ps2(8'h1C);
        check("enabled_irq", 16'(irq1), 16'h1);
        rd(16'h60, 8'h9E, "rel_tracked_disabled");

        // Flush with preloaded FIFO; empty read returns hold
        repeat (3) ps2(8'h16);
        wr(16'h64, 8'hAE);
        rd(16'h64, 8'h00, "flush_preload");
        rd(16'h60, 8'h9E, "flush_hold");
        // Flush on the same edge as a push: byte lost
        step(1'b1, 8'h16, 1'b1, 1'b1, 16'h64, 8'hAE);
        rd(16'h64, 8'h00, "flush_vs_push");
        // Push and pop on empty FIFO: hold returned, byte kept
        rd_hit(16'h60, 1'b1, 8'h16, 8'h9E, "empty_pushpop");
        rd(16'h64, 8'h01, "empty_pushpop_status");
        rd(16'h60, 8'h02, "empty_pushpop_data");

        // Asynchronous reset mid-sequence (after F0)
        wr(16'h3D4, 8'h0E);
        wr(16'h3D5, 8'h03);
        ps2(8'h1C);
        rd(16'h1234, 8'hFF, "pre_reset_read");
        ps2(8'hF0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_port_i", 16'(port_i), 16'h0000);
        check("arst_irq1", 16'(irq1), 16'h0000);
        check("arst_cursor", 16'(vga_cursor), 16'h0000);
        check("arst_start", 16'(vga_start), 16'h0000);
        check("arst_shape", 16'(cursor_shape), 16'h00C7);
        @(negedge clock);
        reset_n = 1'b1;
        ps2(8'h1C);
        rd(16'h60, 8'h1E, "post_reset_rel_clear");
        rd(16'h3D4, 8'h00, "post_reset_idx");
        rd(16'h64, 8'h00, "post_reset_status");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
